// File: rtl/decode_issue_arbiter_pkg.sv
// Shared decode definitions: functional-unit IDs, instruction-format codes,
// payload field layout and the round-robin index helper.
package decode_pkg;

   typedef enum logic [2:0] {
      FU_FX     = 3'd0,
      FU_FP     = 3'd1,
      FU_VX     = 3'd2,
      FU_CR     = 3'd3,
      FU_LS     = 3'd4,
      FU_BRANCH = 3'd6
   } fu_type_e;

   typedef enum logic [5:0] {
      FMT_B  = 6'b000001,
      FMT_D  = 6'b000010,
      FMT_X  = 6'b000100,
      FMT_XO = 6'b001000,
      FMT_M  = 6'b010000,
      FMT_I  = 6'b100000
   } fmt_e;

   // Field offsets inside the 160-bit decoded payload.
   localparam int PL_OPCODE_LSB = 0;
   localparam int PL_OPCODE_W   = 32;
   localparam int PL_ADDR_LSB   = 32;
   localparam int PL_ADDR_W     = 64;
   localparam int PL_MAJOR_LSB  = 96;
   localparam int PL_MAJOR_W    = 8;
   localparam int PL_MINOR_LSB  = 104;
   localparam int PL_MINOR_W    = 4;
   localparam int PL_FU_LSB     = 108;
   localparam int PL_FU_W       = 3;
   localparam int PL_FMT_LSB    = 111;
   localparam int PL_FMT_W      = 6;
   localparam int PL_FLAGS_LSB  = 117;
   localparam int PL_FLAGS_W    = 11;
   localparam int PL_BODY_LSB   = 128;
   localparam int PL_BODY_W     = 32;

   function automatic int rr_index(input int base, input int offset, input int n);
      return (base + offset) % n;
   endfunction

endpackage

// File: rtl/decode_issue_arbiter_if.sv
// Lane-side and issue-side bundle between the Decode-2 lanes, the arbiter
// and the issue stage.
interface decode_issue_arbiter_if #(
   parameter int NumLanes     = 4,
   parameter int PayloadWidth = 160,
   parameter int LaneIdWidth  = 2
);
   logic                             flush_i;
   logic [NumLanes-1:0]              laneValid_i;
   logic [NumLanes*PayloadWidth-1:0] lanePayload_i;
   logic [NumLanes-1:0]              laneStall_o;
   logic                             issueStall_i;
   logic                             issueValid_o;
   logic [PayloadWidth-1:0]          issuePayload_o;
   logic [LaneIdWidth-1:0]           issueLane_o;
   logic                             overflow_o;

   modport master (
      output flush_i, laneValid_i, lanePayload_i, issueStall_i,
      input  laneStall_o, issueValid_o, issuePayload_o, issueLane_o, overflow_o
   );

   modport slave (
      input  flush_i, laneValid_i, lanePayload_i, issueStall_i,
      output laneStall_o, issueValid_o, issuePayload_o, issueLane_o, overflow_o
   );
endinterface

// File: rtl/decode_issue_arbiter_lane_fifo.sv
// Per-lane instruction FIFO; head is read combinationally so the arbiter's
// output register can capture it in the grant cycle.
module decode_lane_fifo #(
   parameter  int PayloadWidth = 160,
   parameter  int FifoDepth    = 4,
   localparam int PtrW         = $clog2(FifoDepth),
   localparam int CntW         = PtrW + 1
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  logic                    i_push,
   input  logic                    i_pop,
   input  logic                    i_flush,
   input  logic [PayloadWidth-1:0] i_data,
   output logic [PayloadWidth-1:0] o_data,
   output logic                    o_empty,
   output logic                    o_full,
   output logic [CntW-1:0]         o_occupancy
);
   logic [PayloadWidth-1:0] r_mem [FifoDepth];
   logic [PtrW-1:0]         r_wr_ptr;
   logic [PtrW-1:0]         r_rd_ptr;
   logic [CntW-1:0]         r_count;
   logic                    w_push;
   logic                    w_pop;

   assign o_empty     = (r_count == '0);
   assign o_full      = (r_count == CntW'(FifoDepth));
   assign o_occupancy = r_count;
   assign o_data      = r_mem[r_rd_ptr];

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_pop  = i_pop && !o_empty && !i_flush;
   assign w_push = i_push && (!o_full || w_pop) && !i_flush;

   always_ff @(posedge clock_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
      end
   end
endmodule

// File: rtl/decode_issue_arbiter.sv
// Merges per-lane decoder outputs into one issue stream through lane FIFOs,
// a round-robin grant and a registered output stage.
module decode_issue_arbiter
   import decode_pkg::*;
#(
   parameter int NumLanes     = 4,
   parameter int PayloadWidth = 160,
   parameter int FifoDepth    = 4,
   parameter int LaneIdWidth  = 2
) (
   input  logic               clock_i,
   input  logic               reset_i,
   decode_issue_arbiter_if.slave bus
);
   localparam int CntW = $clog2(FifoDepth) + 1;

   logic [PayloadWidth-1:0] w_head [NumLanes];
   logic [CntW-1:0]         w_occ  [NumLanes];
   logic [NumLanes-1:0]     w_empty;
   logic [NumLanes-1:0]     w_full;
   logic [NumLanes-1:0]     w_pop;
   logic [NumLanes-1:0]     w_lane_stall;
   logic [NumLanes-1:0]     w_overflow_hit;
   logic [LaneIdWidth-1:0]  w_grant;
   logic                    w_any;
   logic                    w_load;

   logic                    r_valid;
   logic [PayloadWidth-1:0] r_payload;
   logic [LaneIdWidth-1:0]  r_lane;
   logic [LaneIdWidth-1:0]  r_last;
   logic                    r_overflow;

   assign w_load = !r_valid || !bus.issueStall_i;

   for (genvar gi = 0; gi < NumLanes; gi++) begin : g_lane
      decode_lane_fifo #(
         .PayloadWidth (PayloadWidth),
         .FifoDepth    (FifoDepth)
      ) u_fifo (
         .clock_i     (clock_i),
         .reset_i     (reset_i),
         .i_push      (bus.laneValid_i[gi]),
         .i_pop       (w_pop[gi]),
         .i_flush     (bus.flush_i),
         .i_data      (bus.lanePayload_i[gi*PayloadWidth +: PayloadWidth]),
         .o_data      (w_head[gi]),
         .o_empty     (w_empty[gi]),
         .o_full      (w_full[gi]),
         .o_occupancy (w_occ[gi])
      );

      // One slot of margin covers the decoder's already-registered output.
      assign w_lane_stall[gi]   = (w_occ[gi] >= CntW'(FifoDepth - 1));
      assign w_pop[gi]          = w_load && w_any && !bus.flush_i &&
                                  (w_grant == LaneIdWidth'(gi));
      assign w_overflow_hit[gi] = bus.laneValid_i[gi] && w_full[gi] &&
                                  !w_pop[gi] && !bus.flush_i;
   end

   // Descending scan so the lane closest after r_last wins.
   always_comb begin
      w_grant = '0;
      w_any   = 1'b0;
      for (int i = NumLanes; i >= 1; i--) begin
         int idx;
         idx = rr_index(int'(r_last), i, NumLanes);
         if (!w_empty[idx]) begin
            w_grant = LaneIdWidth'(idx);
            w_any   = 1'b1;
         end
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         r_valid    <= 1'b0;
         r_payload  <= '0;
         r_lane     <= '0;
         r_last     <= LaneIdWidth'(NumLanes - 1);
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= r_overflow | (|w_overflow_hit);
         if (bus.flush_i) begin
            r_valid <= 1'b0;
         end else if (w_load) begin
            r_valid <= w_any;
            if (w_any) begin
               r_payload <= w_head[w_grant];
               r_lane    <= w_grant;
               r_last    <= w_grant;
            end
         end
      end
   end

   assign bus.laneStall_o    = w_lane_stall;
   assign bus.issueValid_o   = r_valid;
   assign bus.issuePayload_o = r_payload;
   assign bus.issueLane_o    = r_lane;
   assign bus.overflow_o     = r_overflow;
endmodule

// File: tb/tb_decode_issue_arbiter.sv
// Directed scoreboard bench for decode_issue_arbiter: stimulus queues expected
// issues, a negedge monitor pops and compares each accepted issue.
module tb_decode_issue_arbiter;
   localparam int NL = 4;
   localparam int PW = 160;
   localparam int LW = 2;

   typedef struct {
      logic [LW-1:0] lane;
      logic [PW-1:0] pl;
   } exp_t;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   exp_t sb[$];

   decode_issue_arbiter_if #(.NumLanes(NL), .PayloadWidth(PW), .LaneIdWidth(LW)) bus ();

   decode_issue_arbiter #(
      .NumLanes     (NL),
      .PayloadWidth (PW),
      .FifoDepth    (4),
      .LaneIdWidth  (LW)
   ) dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_lane(input int k, input logic [PW-1:0] val, input bit expect_issue);
      bus.laneValid_i[k]             = 1'b1;
      bus.lanePayload_i[k*PW +: PW]  = val;
      if (expect_issue) sb.push_back('{lane: LW'(k), pl: val});
   endtask

   task automatic clear_lanes();
      bus.laneValid_i   = '0;
      bus.lanePayload_i = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_lanes();
      bus.flush_i      = 1'b0;
      bus.issueStall_i = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && bus.issueValid_o && !bus.issueStall_i) begin : mon
         exp_t e;
         $display("[TB] issue lane %0d payload %0h", bus.issueLane_o, bus.issuePayload_o);
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_issue: got lane %0d payload %0h, required no issue",
                     bus.issueLane_o, bus.issuePayload_o);
         end else begin
            e = sb.pop_front();
            check("issue_lane", PW'(bus.issueLane_o), PW'(e.lane));
            check("issue_payload", bus.issuePayload_o, e.pl);
         end
      end
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      clear_lanes();
      bus.flush_i      = 1'b0;
      bus.issueStall_i = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_valid",    PW'(bus.issueValid_o), 0);
      check("rst_payload",  bus.issuePayload_o, 0);
      check("rst_lane",     PW'(bus.issueLane_o), 0);
      check("rst_overflow", PW'(bus.overflow_o), 0);
      check("rst_stall",    PW'(bus.laneStall_o), 0);

      // 1: single lane-2 instruction, latency and one-cycle valid
      push_lane(2, 'hA5, 1);
      tick(); clear_lanes();
      check("s1_not_yet",  PW'(bus.issueValid_o), 0);
      tick();
      check("s1_valid",    PW'(bus.issueValid_o), 1);
      check("s1_lane",     PW'(bus.issueLane_o), 2);
      check("s1_payload",  bus.issuePayload_o, 'hA5);
      tick();
      check("s1_one_cycle", PW'(bus.issueValid_o), 0);

      // 2: round-robin from reset, twice, then rotation from lastGrant=1
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < NL; k++) push_lane(k, PW'(k + 1), 1);
         tick(); clear_lanes();
         for (int k = 0; k < NL; k++) begin
            tick();
            check("s2_order", PW'(bus.issueLane_o), PW'(k));
         end
         tick();
         check("s2_idle", PW'(bus.issueValid_o), 0);
      end
      push_lane(1, 'h21, 1);
      tick(); clear_lanes();
      tick();
      push_lane(0, 'h10, 0);
      push_lane(2, 'h12, 0);
      push_lane(3, 'h13, 0);
      sb.push_back('{lane: 2'd2, pl: PW'('h12)});
      sb.push_back('{lane: 2'd3, pl: PW'('h13)});
      sb.push_back('{lane: 2'd0, pl: PW'('h10)});
      tick(); clear_lanes();
      tick(); check("s2_rot_a", PW'(bus.issueLane_o), 2);
      tick(); check("s2_rot_b", PW'(bus.issueLane_o), 3);
      tick(); check("s2_rot_c", PW'(bus.issueLane_o), 0);
      tick();

      // 3: lane 1 streams against a stalled issue stage, honouring laneStall_o
      bus.issueStall_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("s3_no_stall", PW'(bus.laneStall_o), 0);
         push_lane(1, PW'('h300 + k), 1);
         tick(); clear_lanes();
      end
      check("s3_stall_rise", PW'(bus.laneStall_o), 'b0010);
      bus.issueStall_i = 1'b0;
      for (int k = 4; k < 6; k++) begin
         int w;
         w = 0;
         while (bus.laneStall_o[1] && w < 20) begin
            tick();
            w++;
         end
         if (w >= 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL s3_stall_timeout: laneStall_o[1] got 1 for 20 cycles, required release");
         end
         push_lane(1, PW'('h300 + k), 1);
         tick(); clear_lanes();
      end
      repeat (10) tick();
      check("s3_overflow", PW'(bus.overflow_o), 0);
      check("s3_drained",  PW'(sb.size()), 0);

      // 4: five pushes into lane 0 behind an occupied, stalled output
      bus.issueStall_i = 1'b1;
      push_lane(3, 'h400, 1);
      tick(); clear_lanes();
      for (int k = 0; k < 5; k++) begin
         push_lane(0, PW'('h410 + k), k < 4);
         tick(); clear_lanes();
         if (k == 3) check("s4_no_overflow_yet", PW'(bus.overflow_o), 0);
         if (k == 4) check("s4_overflow_set",    PW'(bus.overflow_o), 1);
      end
      bus.issueStall_i = 1'b0;
      repeat (10) tick();
      check("s4_overflow_sticky", PW'(bus.overflow_o), 1);
      check("s4_drained",         PW'(sb.size()), 0);

      // 5: flush with lanes 0 and 3 holding three entries each
      bus.issueStall_i = 1'b1;
      push_lane(1, 'h500, 0);
      tick(); clear_lanes();
      for (int k = 0; k < 3; k++) begin
         push_lane(0, PW'('h510 + k), 0);
         push_lane(3, PW'('h530 + k), 0);
         tick(); clear_lanes();
      end
      check("s5_valid_before", PW'(bus.issueValid_o), 1);
      check("s5_stall_before", PW'(bus.laneStall_o), 'b1001);
      bus.flush_i = 1'b1;
      push_lane(0, 'h5FF, 0);
      tick(); clear_lanes();
      bus.flush_i = 1'b0;
      check("s5_valid_after",  PW'(bus.issueValid_o), 0);
      check("s5_stall_after",  PW'(bus.laneStall_o), 0);
      check("s5_overflow_kept", PW'(bus.overflow_o), 1);
      bus.issueStall_i = 1'b0;
      repeat (6) tick();
      check("s5_stays_idle", PW'(bus.issueValid_o), 0);

      // 6: asynchronous reset between edges while the stream is stalled
      bus.issueStall_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         push_lane(0, PW'('h600 + k), 0);
         push_lane(2, PW'('h620 + k), 0);
         tick(); clear_lanes();
      end
      check("s6_valid_before", PW'(bus.issueValid_o), 1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("s6_rst_valid",    PW'(bus.issueValid_o), 0);
      check("s6_rst_payload",  bus.issuePayload_o, 0);
      check("s6_rst_lane",     PW'(bus.issueLane_o), 0);
      check("s6_rst_overflow", PW'(bus.overflow_o), 0);
      check("s6_rst_stall",    PW'(bus.laneStall_o), 0);
      tick();
      rst = 1'b0;
      bus.issueStall_i = 1'b0;
      push_lane(0, 'h6A5, 1);
      tick(); clear_lanes();
      check("s6_not_yet", PW'(bus.issueValid_o), 0);
      tick();
      check("s6_valid",   PW'(bus.issueValid_o), 1);
      check("s6_lane",    PW'(bus.issueLane_o), 0);
      check("s6_payload", bus.issuePayload_o, 'h6A5);
      tick();
      check("s6_one_cycle", PW'(bus.issueValid_o), 0);
      repeat (3) tick();
      check("final_drained", PW'(sb.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
